mag_approx_arbiter: RTL
=======================

// Module: mag_approx_arbiter
// PURPOSE
//  Shares one magnitude_approx pipeline between NUM_CH I/Q requesters.
//  Round-robin arbitration, one sample per clock. Each sample's channel tag
//  travels alongside the fixed-latency datapath. Results, tagged by channel,
//  go into a credit-protected result FIFO that downstream can backpressure.
//  Sits upstream of the per-channel exp_integrator instances.
// PARAMETERS
//  DATA_WIDTH   16  I/Q sample and magnitude width
//  NUM_CH       4   number of requesters (>=2)
//  CH_W         2   channel tag width, = clog2(NUM_CH)
//  MAG_LATENCY  2   i_Re/i_Im -> o_mag_approx latency of magnitude_approx, cycles
//  FIFO_DEPTH   8   result FIFO entries (>= MAG_LATENCY+1)
// PORTS
//  i_clk         in   1                  clock, rising edge
//  i_rst         in   1                  asynchronous, active-high reset
//  i_req_valid   in   NUM_CH             per-channel sample valid
//  i_req_Re      in   NUM_CH*DATA_WIDTH  signed Re, ch k at [k*DW +: DW]
//  i_req_Im      in   NUM_CH*DATA_WIDTH  signed Im, same packing
//  o_req_ready   out  NUM_CH             one-hot grant; transfer = valid&ready
//  o_mag_Re      out  DATA_WIDTH         registered operand to magnitude_approx
//  o_mag_Im      out  DATA_WIDTH         registered operand to magnitude_approx
//  i_mag_approx  in   DATA_WIDTH         result from magnitude_approx
//  o_res_valid   out  1                  result FIFO not empty
//  o_res_ch      out  CH_W               channel tag of head result
//  o_res_data    out  DATA_WIDTH         head magnitude
//  i_res_ready   in   1                  downstream pop; pop = valid&ready
// BEHAVIOUR
//  Reset: o_req_ready=0, o_mag_Re/Im=0, o_res_valid=0, o_res_ch=0, o_res_data=0.
//   Also RR pointer=0, tag pipe cleared, FIFO emptied.
//  Reset mid-operation: in-flight and buffered results are discarded.
//   Results emerging after reset release are ignored (tag-valid pipe cleared).
//  Credits: credits = FIFO_DEPTH - fifo_count - inflight.
//   inflight = number of set valid bits in the tag pipe.
//  Grant: combinational from i_req_valid, RR pointer and credits>0.
//   Search starts at the pointer, increasing index, wraps at NUM_CH-1 -> 0.
//   At most one bit of o_req_ready is set.
//   o_req_ready is 0 for all channels when credits==0 or no valid.
//  On grant to ch k: RR pointer <= (k+1) mod NUM_CH.
//   o_mag_Re/Im <= ch k operands. tag pipe stage0 <= {1,k}.
//   With no grant: o_mag_Re/Im <= 0 and stage0 valid <= 0.
//  Tag pipe: MAG_LATENCY stages after stage0.
//   Push happens when the final stage is valid, with {tag, i_mag_approx}.
//   Grant edge to FIFO-write edge = 1+MAG_LATENCY cycles.
//   First result is visible on o_res_* at 2+MAG_LATENCY cycles.
//  FIFO: first-word-fall-through, registered head.
//   Simultaneous push+pop is legal at any occupancy, count unchanged.
//   Pop when empty: ignored.
//   Push when full: cannot occur by credit rule; bench asserts it.
//  Full throughput: 1 result/cycle when i_res_ready is held 1.
//  Per-channel ordering is preserved; global order = grant order.
// STRUCTURE
//  Shared package env_pkg: DATA_WIDTH, NUM_CH, CH_W, MAG_LATENCY defaults.
//   Also the tag record {valid, ch} and the result record {ch, data}.
//  Sub-module env_result_fifo: sync FIFO with count output.
//   Parameterised by width and FIFO_DEPTH.
//  Arbiter, credit counter and tag pipe stay in this module.
// TESTING
//  1. All 4 valid, i_res_ready=1, operands (3,4) per ch.
//     -> grants ch0,1,2,3,0... one per cycle.
//     -> o_res_ch sequence 0,1,2,3, data = model(3,4), first at cycle 4.
//  2. Only ch2 valid for 5 cycles.
//     -> ready[2]=1 every cycle, 5 results tagged 2.
//     -> pointer=3 afterwards; ch1+ch3 then valid -> ch3 is granted first.
//  3. i_res_ready=0, all valid.
//     -> exactly 8 grants, then o_req_ready=0.
//     -> raise i_res_ready for 1 cycle -> exactly 1 new grant; FIFO never overflows.
//  4. FIFO at count 8 with push+pop in the same cycle.
//     -> count stays 8, head advances, no data loss.
//  5. i_rst pulse with 3 in flight and 4 buffered.
//     -> all outputs 0 asynchronously.
//     -> no o_res_valid for stale data after release.
//  6. Extremes: Re=-32768, Im=32767 on ch1.
//     -> result equals the magnitude_approx reference model, tag 1.

Source files
------------

// File: rtl/mag_approx_arbiter_pkg.sv
// Shared widths, tag/result records and the round-robin step helper for the
// magnitude_approx sharing arbiter.
package mag_approx_arbiter_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int NUM_CH      = 4;
  localparam int CH_W        = 2;
  localparam int MAG_LATENCY = 2;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
  } tag_t;

  typedef struct packed {
    logic [CH_W-1:0]       ch;
    logic [DATA_WIDTH-1:0] data;
  } res_t;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    if (ch == CH_W'(NUM_CH - 1)) begin
      return '0;
    end else begin
      return ch + CH_W'(1);
    end
  endfunction

endpackage

// File: rtl/mag_approx_arbiter_if.sv
// Requester, magnitude_approx and result-FIFO signals of the arbiter.
// The arbiter uses the slave side; the environment drives the master side.
interface mag_approx_arbiter_if;
  import mag_approx_arbiter_pkg::*;

  logic [NUM_CH-1:0]            i_req_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] i_req_Re;
  logic [NUM_CH*DATA_WIDTH-1:0] i_req_Im;
  logic [NUM_CH-1:0]            o_req_ready;
  logic [DATA_WIDTH-1:0]        o_mag_Re;
  logic [DATA_WIDTH-1:0]        o_mag_Im;
  logic [DATA_WIDTH-1:0]        i_mag_approx;
  logic                         o_res_valid;
  logic [CH_W-1:0]              o_res_ch;
  logic [DATA_WIDTH-1:0]        o_res_data;
  logic                         i_res_ready;

  modport slave (
    input  i_req_valid, i_req_Re, i_req_Im, i_mag_approx, i_res_ready,
    output o_req_ready, o_mag_Re, o_mag_Im, o_res_valid, o_res_ch, o_res_data
  );

  modport master (
    output i_req_valid, i_req_Re, i_req_Im, i_mag_approx, i_res_ready,
    input  o_req_ready, o_mag_Re, o_mag_Im, o_res_valid, o_res_ch, o_res_data
  );

endinterface

// File: rtl/mag_approx_arbiter_result_fifo.sv
// First-word-fall-through sync FIFO with occupancy count; head is driven from
// flops only and reads as zero while empty.
module mag_approx_arbiter_result_fifo #(
  parameter  int WIDTH = 18,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_s;
  logic             pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign valid_s = (count_q != '0);
  // A pop against an empty FIFO is dropped here rather than by the caller.
  assign pop_s   = i_pop && valid_s;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (i_push) begin
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({i_push, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through a non-zero count.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      mem_q[wr_ptr_q] <= i_push_data;
    end
  end

  assign o_valid = valid_s;
  assign o_data  = valid_s ? mem_q[rd_ptr_q] : '0;
  assign o_count = count_q;

endmodule

// File: rtl/mag_approx_arbiter.sv
// Round-robin sharing of one magnitude_approx pipeline between NUM_CH I/Q
// requesters, with channel tags riding a valid pipe into a credit-guarded FIFO.
module mag_approx_arbiter
  import mag_approx_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input logic                 i_clk,
  input logic                 i_rst,
  mag_approx_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(MAG_LATENCY + 2);
  localparam int SUM_W = CNT_W + 1;

  logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] mag_re_q, mag_re_d;
  logic [DATA_WIDTH-1:0] mag_im_q, mag_im_d;
  tag_t                  tag_q [MAG_LATENCY+1];
  tag_t                  tag_d [MAG_LATENCY+1];

  logic [NUM_CH-1:0] grant_s;
  logic              grant_any_s;
  logic [CH_W-1:0]   grant_ch_s;
  int                cand_idx;
  logic [INF_W-1:0]  inflight_s;
  logic              credit_ok_s;

  logic              fifo_push_s;
  res_t              fifo_wdata_s;
  res_t              fifo_rdata_s;
  logic              fifo_valid_s;
  logic [CNT_W-1:0]  fifo_count_s;

  // Every valid tag already owns a FIFO slot, so it is charged against credits.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i <= MAG_LATENCY; i++) begin
      if (tag_q[i].valid) begin
        inflight_s = inflight_s + INF_W'(1);
      end else begin
        inflight_s = inflight_s;
      end
    end
  end

  assign credit_ok_s = (SUM_W'(fifo_count_s) + SUM_W'(inflight_s)) < SUM_W'(FIFO_DEPTH);

  always_comb begin
    grant_any_s = 1'b0;
    grant_ch_s  = '0;
    cand_idx    = 0;
    if (!i_rst && credit_ok_s) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cand_idx = (int'(rr_ptr_q) + i) % NUM_CH;
        if (!grant_any_s && bus.i_req_valid[cand_idx]) begin
          grant_any_s = 1'b1;
          grant_ch_s  = CH_W'(cand_idx);
        end else begin
          grant_any_s = grant_any_s;
        end
      end
    end else begin
      grant_any_s = 1'b0;
    end
    grant_s = grant_any_s ? (NUM_CH'(1) << grant_ch_s) : '0;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    mag_re_d = '0;
    mag_im_d = '0;
    tag_d[0] = '{valid: grant_any_s, ch: grant_ch_s};
    for (int i = 1; i <= MAG_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    if (grant_any_s) begin
      rr_ptr_d = next_ch(grant_ch_s);
      mag_re_d = bus.i_req_Re[int'(grant_ch_s)*DATA_WIDTH +: DATA_WIDTH];
      mag_im_d = bus.i_req_Im[int'(grant_ch_s)*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rr_ptr_q <= '0;
      mag_re_q <= '0;
      mag_im_q <= '0;
      for (int i = 0; i <= MAG_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      mag_re_q <= mag_re_d;
      mag_im_q <= mag_im_d;
      for (int i = 0; i <= MAG_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  // The last tag stage lines up with i_mag_approx for the same sample.
  assign fifo_push_s  = tag_q[MAG_LATENCY].valid;
  assign fifo_wdata_s = '{ch: tag_q[MAG_LATENCY].ch, data: bus.i_mag_approx};

  mag_approx_arbiter_result_fifo #(
    .WIDTH ($bits(res_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (fifo_push_s),
    .i_push_data (fifo_wdata_s),
    .i_pop       (bus.i_res_ready),
    .o_valid     (fifo_valid_s),
    .o_data      (fifo_rdata_s),
    .o_count     (fifo_count_s)
  );

  assign bus.o_req_ready = grant_s;
  assign bus.o_mag_Re    = mag_re_q;
  assign bus.o_mag_Im    = mag_im_q;
  assign bus.o_res_valid = fifo_valid_s;
  assign bus.o_res_ch    = fifo_rdata_s.ch;
  assign bus.o_res_data  = fifo_rdata_s.data;

endmodule
